// File: rtl/sa_pkg.sv
// Shared constants and FSM state type for the systolic array write-back path.
package sa_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned DIM_WIDTH  = 6;
  localparam int unsigned WRITE_BW   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/sa_wb_addr_accum.sv
// Row base-address accumulator: loads the matrix base, then steps by the
// row stride (zero-extended) each time a full row has been written.
module sa_wb_addr_accum
  import sa_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic                  en_i,
  input  logic [DIM_WIDTH-1:0]  stride_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;

  // Next row address: load wins over advance; arithmetic wraps naturally
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = base_i;
    end else if (en_i) begin
      addr_d = addr_q + {{(ADDR_WIDTH-DIM_WIDTH){1'b0}}, stride_i};
    end
  end

  // Row address register, cleared by the asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/systolic_writeback.sv
// Writes an N x N result matrix back to memory in BW-word chunks, row by row.
// Optional build macro SA_WB_TRANSPOSE_EN: emit C transposed (column r of the
// captured matrix becomes memory row r); addressing and timing are unchanged.
// N must be a multiple of BW.
module systolic_writeback
  import sa_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned BW = WRITE_BW
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_C,
  input  logic [DIM_WIDTH-1:0]         dim_col_C,
  input  logic [N*N*DATA_WIDTH-1:0]    Out,
  input  logic                         waitrequest,
  output logic                         write,
  output logic [ADDR_WIDTH-1:0]        write_addr,
  output logic [BW*DATA_WIDTH-1:0]     writedata,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned HN = N / BW;
  localparam int unsigned RW = (N  > 1) ? $clog2(N)  : 1;
  localparam int unsigned HW = (HN > 1) ? $clog2(HN) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(N - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HN - 1);

  wb_state_e state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [HW-1:0] h_q, h_d;
  logic [DIM_WIDTH-1:0] dim_q, dim_d;
  logic [N*N*DATA_WIDTH-1:0] cbuf_q;
  logic [ADDR_WIDTH-1:0] row_addr;
  logic [BW*DATA_WIDTH-1:0] payload;
  logic capture;
  logic row_adv;
  int unsigned idx;

  sa_wb_addr_accum u_addr (
    .clock    (clock),
    .reset    (reset),
    .load_i   (capture),
    .base_i   (base_C),
    .en_i     (row_adv),
    .stride_i (dim_q),
    .addr_o   (row_addr)
  );

  // Select the BW words of the current chunk from the captured matrix
  always_comb begin
    payload = '0;
    idx     = 0;
    for (int unsigned j = 0; j < BW; j++) begin
`ifdef SA_WB_TRANSPOSE_EN
      idx = (32'(h_q) * BW + j) * N + 32'(r_q);
`else
      idx = 32'(r_q) * N + 32'(h_q) * BW + j;
`endif
      payload[j*DATA_WIDTH +: DATA_WIDTH] = cbuf_q[idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // FSM next state, chunk counters and memory-side outputs
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    h_d        = h_q;
    dim_d      = dim_q;
    capture    = 1'b0;
    row_adv    = 1'b0;
    write      = 1'b0;
    write_addr = '0;
    writedata  = '0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          dim_d   = dim_col_C;
          r_d     = '0;
          h_d     = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy       = 1'b1;
        write      = 1'b1;
        write_addr = row_addr + ADDR_WIDTH'(32'(h_q) * BW);
        writedata  = payload;
        if (!waitrequest) begin
          if (h_q == H_LAST) begin
            h_d     = '0;
            row_adv = 1'b1;
            if (r_q == R_LAST) begin
              state_d = DONE;
            end else begin
              r_d = r_q + RW'(1);
            end
          end else begin
            h_d = h_q + HW'(1);
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state; reset abandons any transfer in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      h_q     <= '0;
      dim_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      h_q     <= h_d;
      dim_q   <= dim_d;
    end
  end

  // Matrix capture buffer; contents are only meaningful after a capture
  always_ff @(posedge clock) begin
    if (capture) begin
      cbuf_q <= Out;
    end
  end

endmodule

// File: tb/tb_systolic_writeback.sv
// Directed self-checking bench for systolic_writeback (N=8, BW=4).
module tb_systolic_writeback;
  import sa_pkg::*;

  localparam int N  = 8;
  localparam int BW = 4;
  localparam int HN = N / BW;
  localparam int NW = N * N / BW;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic [11:0]          base_C;
  logic [5:0]           dim_col_C;
  logic [N*N*32-1:0]    Out;
  logic                 waitrequest;
  logic                 write;
  logic [11:0]          write_addr;
  logic [BW*32-1:0]     writedata;
  logic                 busy;
  logic                 done;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  systolic_writeback #(.N(N), .BW(BW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base_C      (base_C),
    .dim_col_C   (dim_col_C),
    .Out         (Out),
    .waitrequest (waitrequest),
    .write       (write),
    .write_addr  (write_addr),
    .writedata   (writedata),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [31:0] elem(int r, int c);
    return 32'(16 * r + c);
  endfunction

  function automatic logic [BW*32-1:0] exp_data(int k);
    logic [BW*32-1:0] d;
    int r;
    int h;
    r = k / HN;
    h = k % HN;
    d = '0;
    for (int j = 0; j < BW; j++) begin
`ifdef SA_WB_TRANSPOSE_EN
      d[j*32 +: 32] = elem(h * BW + j, r);
`else
      d[j*32 +: 32] = elem(r, h * BW + j);
`endif
    end
    return d;
  endfunction

  function automatic logic [11:0] exp_addr(int base, int dim, int k);
    return 12'(base + (k / HN) * dim + (k % HN) * BW);
  endfunction

  task automatic fill_pattern();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        Out[(r*N + c)*32 +: 32] = elem(r, c);
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; waitrequest = 1'b0;
    base_C = 12'd100; dim_col_C = 6'd8;
    fill_pattern();
    repeat (2) @(negedge clock);
    total++;
    if ({write, busy, done, write_addr, writedata} !== '0) begin
      bad++;
      $display("FAIL reset_held: write=%b busy=%b done=%b addr=%0d data=%h, want all zero",
               write, busy, done, write_addr, writedata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({write, busy, done, write_addr, writedata} !== '0) begin
      bad++;
      $display("FAIL reset_released: write=%b busy=%b done=%b addr=%0d data=%h, want all zero",
               write, busy, done, write_addr, writedata);
    end
  endtask

  task automatic test_basic();
    logic [BW*32-1:0] first_exp, second_exp, last_exp;
    int k;
    int done_cyc;
`ifdef SA_WB_TRANSPOSE_EN
    first_exp  = {32'd48, 32'd32, 32'd16, 32'd0};
    second_exp = {32'd112, 32'd96, 32'd80, 32'd64};
    last_exp   = {32'd119, 32'd103, 32'd87, 32'd71};
`else
    first_exp  = {32'd3, 32'd2, 32'd1, 32'd0};
    second_exp = {32'd7, 32'd6, 32'd5, 32'd4};
    last_exp   = {32'd119, 32'd118, 32'd117, 32'd116};
`endif
    base_C = 12'd100; dim_col_C = 6'd8;
    do_start();
    k = 0; done_cyc = 0;
    for (int cyc = 1; cyc <= NW + 5; cyc++) begin
      @(negedge clock);
      if (k < NW) begin
        total++;
        if (write !== 1'b1 || busy !== 1'b1 || write_addr !== exp_addr(100, 8, k) || writedata !== exp_data(k)) begin
          bad++;
          $display("FAIL basic_write k=%0d: write=%b busy=%b addr=%0d data=%h, want 1 1 %0d %h",
                   k, write, busy, write_addr, writedata, exp_addr(100, 8, k), exp_data(k));
        end
        if (k == 0) begin
          total++;
          if (write_addr !== 12'd100 || writedata !== first_exp) begin
            bad++;
            $display("FAIL basic_first: addr=%0d data=%h, want 100 %h", write_addr, writedata, first_exp);
          end
        end
        if (k == 1) begin
          total++;
          if (write_addr !== 12'd104 || writedata !== second_exp) begin
            bad++;
            $display("FAIL basic_second: addr=%0d data=%h, want 104 %h", write_addr, writedata, second_exp);
          end
        end
        if (k == NW - 1) begin
          total++;
          if (write_addr !== 12'd160 || writedata !== last_exp) begin
            bad++;
            $display("FAIL basic_last: addr=%0d data=%h, want 160 %h", write_addr, writedata, last_exp);
          end
        end
        k++;
      end else begin
        total++;
        if (done !== 1'b1 || write !== 1'b0 || write_addr !== 12'd0) begin
          bad++;
          $display("FAIL basic_done_pulse: done=%b write=%b addr=%0d, want 1 0 0", done, write, write_addr);
        end
        done_cyc = cyc;
        break;
      end
    end
    total++;
    if (done_cyc != 17) begin
      bad++;
      $display("FAIL basic_done_cycle: got %0d, want 17", done_cyc);
    end
    @(negedge clock);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || write !== 1'b0) begin
      bad++;
      $display("FAIL basic_after_done: done=%b busy=%b write=%b, want 0 0 0", done, busy, write);
    end
  endtask

  task automatic test_stall();
    int k;
    int done_cyc;
    int held;
    base_C = 12'd100; dim_col_C = 6'd8;
    do_start();
    k = 0; done_cyc = 0; held = 0;
    for (int cyc = 1; cyc <= NW + 10; cyc++) begin
      @(negedge clock);
      if (k < NW) begin
        total++;
        if (write !== 1'b1 || write_addr !== exp_addr(100, 8, k) || writedata !== exp_data(k)) begin
          bad++;
          $display("FAIL stall_write k=%0d cyc=%0d: write=%b addr=%0d data=%h, want 1 %0d %h",
                   k, cyc, write, write_addr, writedata, exp_addr(100, 8, k), exp_data(k));
        end
        if (write_addr == 12'd116) held++;
        waitrequest = (cyc >= 5 && cyc <= 7);
        if (!waitrequest) k++;
      end else begin
        waitrequest = 1'b0;
        if (done === 1'b1) begin
          done_cyc = cyc;
          break;
        end
      end
    end
    waitrequest = 1'b0;
    total++;
    if (held != 4) begin
      bad++;
      $display("FAIL stall_hold_116: cycles at 116 = %0d, want 4", held);
    end
    total++;
    if (done_cyc != 20) begin
      bad++;
      $display("FAIL stall_done_cycle: got %0d, want 20", done_cyc);
    end
  endtask

  task automatic test_wrap();
    int k;
    base_C = 12'd4090; dim_col_C = 6'd8;
    do_start();
    k = 0;
    for (int cyc = 1; cyc <= NW + 1; cyc++) begin
      @(negedge clock);
      if (k < NW) begin
        total++;
        if (write !== 1'b1 || write_addr !== exp_addr(4090, 8, k)) begin
          bad++;
          $display("FAIL wrap_addr k=%0d: write=%b addr=%0d, want 1 %0d", k, write, write_addr, exp_addr(4090, 8, k));
        end
        if (k == 2) begin
          total++;
          if (write_addr !== 12'd2) begin
            bad++;
            $display("FAIL wrap_third: addr=%0d, want 2", write_addr);
          end
        end
        if (k == 1) begin
          total++;
          if (write_addr !== 12'd4094) begin
            bad++;
            $display("FAIL wrap_second: addr=%0d, want 4094", write_addr);
          end
        end
        k++;
      end else begin
        total++;
        if (done !== 1'b1) begin
          bad++;
          $display("FAIL wrap_done: done=%b, want 1", done);
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    int k;
    int done_cnt;
    base_C = 12'd100; dim_col_C = 6'd8;
    do_start();
    k = 0; done_cnt = 0;
    for (int cyc = 1; cyc <= NW + 4; cyc++) begin
      @(negedge clock);
      if (k < NW) begin
        total++;
        if (write !== 1'b1 || write_addr !== exp_addr(100, 8, k) || writedata !== exp_data(k)) begin
          bad++;
          $display("FAIL ignore_write k=%0d: write=%b addr=%0d data=%h, want 1 %0d %h",
                   k, write, write_addr, writedata, exp_addr(100, 8, k), exp_data(k));
        end
        k++;
      end else begin
        if (done === 1'b1) done_cnt++;
        if (cyc > NW + 1) begin
          total++;
          if (write !== 1'b0) begin
            bad++;
            $display("FAIL ignore_no_restart cyc=%0d: write=%b, want 0", cyc, write);
          end
        end
      end
      if (cyc == 3) begin
        start = 1'b1;
        Out = '1;
      end else begin
        start = 1'b0;
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL ignore_done_count: got %0d, want 1", done_cnt);
    end
    fill_pattern();
  endtask

  task automatic test_back_to_back();
    base_C = 12'd40; dim_col_C = 6'd8;
    do_start();
    for (int cyc = 1; cyc <= NW; cyc++) @(negedge clock);
    @(negedge clock);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done: done=%b, want 1", done);
    end
    start = 1'b1;
    @(negedge clock);
    total++;
    if (write !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_start_in_done_ignored: write=%b done=%b busy=%b, want 0 0 0", write, done, busy);
    end
    @(negedge clock);
    start = 1'b0;
    total++;
    if (write !== 1'b1 || write_addr !== 12'd40 || writedata !== exp_data(0)) begin
      bad++;
      $display("FAIL b2b_restart: write=%b addr=%0d data=%h, want 1 40 %h", write, write_addr, writedata, exp_data(0));
    end
    begin
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
        @(negedge clock);
        n++;
      end
      total++;
      if (done !== 1'b1) begin
        bad++;
        $display("FAIL b2b_second_done: done=%b after %0d cycles, want 1", done, n);
      end
    end
  endtask

  task automatic test_reset_mid();
    base_C = 12'd200; dim_col_C = 6'd8;
    do_start();
    for (int cyc = 1; cyc <= 7; cyc++) @(negedge clock);
    total++;
    if (write !== 1'b1 || write_addr !== 12'd224) begin
      bad++;
      $display("FAIL rstmid_seventh: write=%b addr=%0d, want 1 224", write, write_addr);
    end
    reset = 1'b1;
    #1;
    total++;
    if (write !== 1'b0 || busy !== 1'b0 || write_addr !== 12'd0 || writedata !== '0) begin
      bad++;
      $display("FAIL rstmid_immediate: write=%b busy=%b addr=%0d data=%h, want 0 0 0 0",
               write, busy, write_addr, writedata);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_abandoned: write=%b busy=%b done=%b, want 0 0 0", write, busy, done);
    end
    base_C = 12'd300;
    do_start();
    @(negedge clock);
    total++;
    if (write !== 1'b1 || write_addr !== 12'd300 || writedata !== exp_data(0)) begin
      bad++;
      $display("FAIL rstmid_restart: write=%b addr=%0d data=%h, want 1 300 %h", write, write_addr, writedata, exp_data(0));
    end
    begin
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
        @(negedge clock);
        n++;
      end
      total++;
      if (done !== 1'b1) begin
        bad++;
        $display("FAIL rstmid_done: done=%b after %0d cycles, want 1", done, n);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    waitrequest = 1'b0;
    base_C = '0;
    dim_col_C = '0;
    Out = '0;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
